// File: rtl/uart_frame_gen_if.sv
// Handshake bundle for the UART frame generator: tick, request/payload
// inputs and the serial line plus status outputs.
interface uart_frame_gen_if #(
  parameter int NB_DATA = 8
);
  logic               i_s_tick;
  logic               i_start;
  logic               i_auto;
  logic [NB_DATA-1:0] i_data;
  logic               o_tx;
  logic               o_busy;
  logic               o_done_tick;
  logic [NB_DATA-1:0] o_data;

  // Driver side: paces the generator and requests frames
  modport master (
    output i_s_tick, i_start, i_auto, i_data,
    input  o_tx, o_busy, o_done_tick, o_data
  );

  // Generator side
  modport slave (
    input  i_s_tick, i_start, i_auto, i_data,
    output o_tx, o_busy, o_done_tick, o_data
  );
endinterface

// File: rtl/uart_frame_gen.sv
// UART frame stimulus source. Emits start/data/[parity]/stop frames paced by
// an oversampling tick, either on request or back-to-back from a 16-bit LFSR.
module uart_frame_gen #(
  parameter int          NB_DATA     = 8,
  parameter int          SB_TICK     = 16,
  parameter int          NB_TICK     = 4,
  parameter int          N_STOP      = 1,
  parameter int          PARITY_MODE = 0,
  parameter int          IDLE_BITS   = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic             i_clk,
  input logic             i_reset,
  uart_frame_gen_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } state_t;

  localparam logic [NB_TICK-1:0] TICK_LAST = NB_TICK'(SB_TICK - 1);
  localparam logic [4:0]         DATA_LAST = 5'(NB_DATA - 1);
  localparam logic [4:0]         STOP_LAST = 5'(N_STOP - 1);
  localparam logic [4:0]         GAP_LAST  = 5'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);

  state_t             state_reg;
  logic [NB_TICK-1:0] tick_reg;
  logic [4:0]         bit_reg;
  logic [NB_DATA-1:0] data_reg;
  logic [NB_DATA-1:0] shift_reg;
  logic [NB_DATA-1:0] shift_next;
  logic [15:0]        lfsr_reg;
  logic [15:0]        lfsr_next;
  logic               tx_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               bit_end;
  logic               parity_bit;

  // Fibonacci LFSR, taps 16,14,13,11; a nonzero seed never reaches zero
  assign lfsr_next  = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  // A bit period closes on the tick that completes SB_TICK ticks
  assign bit_end    = bus.i_s_tick && (tick_reg == TICK_LAST);
  assign shift_next = shift_reg >> 1;
  assign parity_bit = (PARITY_MODE == 2) ? ~^data_reg : ^data_reg;

  // Frame sequencer with registered line, busy, done and payload outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      data_reg  <= '0;
      shift_reg <= '0;
      lfsr_reg  <= LFSR_SEED;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      // Tick counter runs only inside a frame; wraps at the end of each bit
      if (state_reg != ST_IDLE && bus.i_s_tick) begin
        tick_reg <= bit_end ? '0 : tick_reg + 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          if (bus.i_start || bus.i_auto) begin
            state_reg <= ST_START;
            tick_reg  <= '0;
            bit_reg   <= '0;
            tx_reg    <= 1'b0;
            busy_reg  <= 1'b1;
            if (bus.i_start) begin
              data_reg  <= bus.i_data;
              shift_reg <= bus.i_data;
            end else begin
              // Auto payload is the current LFSR word; the LFSR then steps once
              data_reg  <= lfsr_reg[NB_DATA-1:0];
              shift_reg <= lfsr_reg[NB_DATA-1:0];
              lfsr_reg  <= lfsr_next;
            end
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_reg <= ST_DATA;
            bit_reg   <= '0;
            tx_reg    <= shift_reg[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_reg == DATA_LAST) begin
              bit_reg <= '0;
              if (PARITY_MODE != 0) begin
                state_reg <= ST_PARITY;
                tx_reg    <= parity_bit;
              end else begin
                state_reg <= ST_STOP;
                tx_reg    <= 1'b1;
              end
            end else begin
              bit_reg   <= bit_reg + 1'b1;
              shift_reg <= shift_next;
              tx_reg    <= shift_next[0];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_reg <= ST_STOP;
            tx_reg    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (bit_reg == STOP_LAST) begin
              done_reg <= 1'b1;
              bit_reg  <= '0;
              if (!bus.i_auto) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end else if (IDLE_BITS == 0) begin
                state_reg <= ST_START;
                tx_reg    <= 1'b0;
                data_reg  <= lfsr_reg[NB_DATA-1:0];
                shift_reg <= lfsr_reg[NB_DATA-1:0];
                lfsr_reg  <= lfsr_next;
              end else begin
                state_reg <= ST_GAP;
              end
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (bit_end) begin
            if (bit_reg == GAP_LAST) begin
              bit_reg <= '0;
              if (bus.i_auto) begin
                state_reg <= ST_START;
                tx_reg    <= 1'b0;
                data_reg  <= lfsr_reg[NB_DATA-1:0];
                shift_reg <= lfsr_reg[NB_DATA-1:0];
                lfsr_reg  <= lfsr_next;
              end else begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              bit_reg <= bit_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_tx        = tx_reg;
  assign bus.o_busy      = busy_reg;
  assign bus.o_done_tick = done_reg;
  assign bus.o_data      = data_reg;

endmodule

// File: tb/tb_uart_frame_gen.sv
// Directed bench for uart_frame_gen: four instances (8N1 with auto gap of 2,
// 8E2, 8O2, 5N1) sharing clock, reset and a tick every 4 clocks (64 clk/bit).
module tb_uart_frame_gen;

  logic        clk;
  logic        rst;
  logic        s_tick;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        start_r [4];
  logic        auto_r  [4];
  logic [15:0] data_r  [4];
  logic        tx_w    [4];
  logic        busy_w  [4];
  logic        done_w  [4];
  logic [15:0] od_w    [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count; tick is high for every fourth rising edge
  always @(posedge clk) cyc <= cyc + 1;
  assign s_tick = (cyc[1:0] == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      localparam int NBD = (gi == 3) ? 5 : 8;
      localparam int PM  = (gi == 1) ? 1 : ((gi == 2) ? 2 : 0);
      localparam int NS  = (gi == 1 || gi == 2) ? 2 : 1;

      uart_frame_gen_if #(.NB_DATA(NBD)) bus ();

      assign bus.i_s_tick = s_tick;
      assign bus.i_start  = start_r[gi];
      assign bus.i_auto   = auto_r[gi];
      assign bus.i_data   = data_r[gi][NBD-1:0];
      assign tx_w[gi]     = bus.o_tx;
      assign busy_w[gi]   = bus.o_busy;
      assign done_w[gi]   = bus.o_done_tick;
      assign od_w[gi]     = 16'(bus.o_data);

      uart_frame_gen #(
        .NB_DATA    (NBD),
        .SB_TICK    (16),
        .NB_TICK    (4),
        .N_STOP     (NS),
        .PARITY_MODE(PM),
        .IDLE_BITS  (2),
        .LFSR_SEED  (16'hACE1)
      ) u_dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
      );
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Return at a falling edge whose following rising edge carries a tick
  task automatic align();
    do @(negedge clk); while (cyc[1:0] != 2'd3);
  endtask

  // One manual frame on instance u. exp_bits lists the line LSB-first, nb bits.
  // inject_n >= 0: pulse i_start with 0xFFFF at that cycle offset.
  // reset_n  >= 0: pulse reset at that cycle offset and abandon the frame.
  task automatic run_frame(input int u, input logic [15:0] d, input logic [31:0] exp_bits,
                           input int nb, input int inject_n, input int reset_n);
    int done_cnt;
    int done_at;
    bit aborted;
    done_cnt = 0;
    done_at  = -1;
    aborted  = 1'b0;
    align();
    start_r[u] = 1'b1;
    data_r[u]  = d;
    @(negedge clk);
    start_r[u] = 1'b0;
    check_eq($sformatf("u%0d busy_on", u), busy_w[u], 1);
    for (int n = 0; n <= nb * 64 + 3 && !aborted; n++) begin
      if (n == reset_n) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq($sformatf("u%0d rst_tx", u), tx_w[u], 1);
        check_eq($sformatf("u%0d rst_busy", u), busy_w[u], 0);
        check_eq($sformatf("u%0d rst_done", u), done_w[u], 0);
        check_eq($sformatf("u%0d rst_data", u), od_w[u], 0);
        for (int k = 0; k < nb * 64; k++) begin
          @(negedge clk);
          if (done_w[u]) done_cnt++;
        end
        check_eq($sformatf("u%0d rst_no_done", u), done_cnt, 0);
        aborted = 1'b1;
      end else begin
        if (n == inject_n) begin
          start_r[u] = 1'b1;
          data_r[u]  = 16'hFFFF;
        end
        if (n == inject_n + 1) start_r[u] = 1'b0;
        if ((n % 64) == 32 && (n / 64) < nb)
          check_eq($sformatf("u%0d tx_bit%0d", u, n / 64), tx_w[u], exp_bits[n / 64]);
        if (n == nb * 32) check_eq($sformatf("u%0d data_mid", u), od_w[u], d);
        if (n == nb * 64 - 1) check_eq($sformatf("u%0d busy_last", u), busy_w[u], 1);
        if (n == nb * 64) check_eq($sformatf("u%0d busy_end", u), busy_w[u], 0);
        if (n == nb * 64 + 2) check_eq($sformatf("u%0d data_end", u), od_w[u], d);
        if (done_w[u]) begin
          done_cnt++;
          done_at = n;
        end
        @(negedge clk);
      end
    end
    if (!aborted) begin
      check_eq($sformatf("u%0d done_cnt", u), done_cnt, 1);
      check_eq($sformatf("u%0d done_at", u), done_at, nb * 64);
      $display("frame u%0d data=%0h bits=%0d done_at=%0d", u, d, nb, done_at);
    end else begin
      $display("frame u%0d data=%0h reset at cycle %0d", u, d, reset_n);
    end
  endtask

  logic [15:0] lfsr_m;
  logic [7:0]  payload;
  logic [9:0]  fbits;

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 4; u++) begin
      start_r[u] = 1'b0;
      auto_r[u]  = 1'b0;
      data_r[u]  = 16'h0000;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      check_eq($sformatf("u%0d reset_tx", u), tx_w[u], 1);
      check_eq($sformatf("u%0d reset_busy", u), busy_w[u], 0);
      check_eq($sformatf("u%0d reset_done", u), done_w[u], 0);
      check_eq($sformatf("u%0d reset_data", u), od_w[u], 0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1,1
    run_frame(0, 16'h00A5, 32'h0000034A, 10, -1, -1);
    // Same frame with a second request (0xFF) mid-DATA that must be ignored
    run_frame(0, 16'h00A5, 32'h0000034A, 10, 64 * 3 + 10, -1);
    // 8E2 0x07: start, 1,1,1,0,0,0,0,0, parity 1, stop, stop
    run_frame(1, 16'h0007, 32'h00000E0E, 12, -1, -1);
    // 8O2 0x07: parity 0
    run_frame(2, 16'h0007, 32'h00000C0E, 12, -1, -1);
    // 5N1 0x13: line 0,1,1,0,0,1,1
    run_frame(3, 16'h0013, 32'h00000066, 7, -1, -1);
    // Reset during data bit 3 (frame bit 4)
    run_frame(0, 16'h00A5, 32'h0000034A, 10, 64 * 4 + 20, 64 * 4 + 20);

    // Auto mode: back-to-back LFSR frames with a 2-bit gap; drop auto in frame 3
    lfsr_m = 16'hACE1;
    align();
    auto_r[0] = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      payload = lfsr_m[7:0];
      lfsr_m  = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      fbits   = {1'b1, payload, 1'b0};
      for (int n = 0; n < 768; n++) begin
        if (f == 2 && n == 100) auto_r[0] = 1'b0;
        if (n == 0 && f > 0) check_eq($sformatf("auto f%0d start_edge", f), tx_w[0], 0);
        if ((n % 64) == 32) begin
          if ((n / 64) < 10)
            check_eq($sformatf("auto f%0d tx_bit%0d", f, n / 64), tx_w[0], fbits[n / 64]);
          else
            check_eq($sformatf("auto f%0d gap%0d", f, n / 64 - 10), tx_w[0], 1);
        end
        if (n == 320) check_eq($sformatf("auto f%0d data", f), od_w[0], payload);
        if (n == 320 && f == 0) check_eq("auto first_payload", od_w[0], 16'h00E1);
        if (n == 320 && f == 1) check_eq("auto second_payload", od_w[0], 16'h00C3);
        if (n == 640) check_eq($sformatf("auto f%0d done", f), done_w[0], 1);
        if (n == 700) check_eq($sformatf("auto f%0d busy_gap", f), busy_w[0], (f < 2) ? 1 : 0);
        if (n == 767) check_eq($sformatf("auto f%0d gap_end", f), tx_w[0], 1);
        @(negedge clk);
      end
      $display("auto frame %0d payload=%0h", f, payload);
    end
    repeat (200) @(negedge clk);
    check_eq("auto stopped_busy", busy_w[0], 0);
    check_eq("auto stopped_tx", tx_w[0], 1);

    // Reset, then auto restart must reproduce the first payload
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    align();
    auto_r[0] = 1'b1;
    @(negedge clk);
    repeat (320) @(negedge clk);
    check_eq("auto restart_payload", od_w[0], 16'h00E1);
    auto_r[0] = 1'b0;
    for (int i = 0; i < 2000 && busy_w[0]; i++) @(negedge clk);
    check_eq("auto restart_idle", busy_w[0], 0);
    $display("auto restart payload=%0h", od_w[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
